// File: rtl/stage_sequencer.sv
// stage_sequencer: walks one instruction at a time through the core's stage enables,
// skipping LSU/RFW when unused, with memory-valid timeouts, boot pass, halt and retire count.
module stage_sequencer #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             boot_i,
  input  logic             halt_i,
  input  logic             ins_rvalid_i,
  input  logic             dat_rvalid_i,
  input  logic             data_req_i,
  input  logic             data_we_i,
  input  logic             rf_we_i,
  output logic             en_boo_o,
  output logic             en_ife_in_o,
  output logic             en_ins_mem_o,
  output logic             en_ife_out_o,
  output logic             en_dec_o,
  output logic             en_rfr_o,
  output logic             en_iss_o,
  output logic             en_alu_o,
  output logic             en_lsu_in_o,
  output logic             en_dat_mem_o,
  output logic             en_lsu_out_o,
  output logic             en_rfw_o,
  output logic             en_pca_o,
  output logic             boot_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instret_o
);
  localparam int WW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_BOO     = 4'd1;
  localparam logic [3:0] S_IFE_IN  = 4'd2;
  localparam logic [3:0] S_INS_MEM = 4'd3;
  localparam logic [3:0] S_IFE_OUT = 4'd4;
  localparam logic [3:0] S_DEC     = 4'd5;
  localparam logic [3:0] S_RFR     = 4'd6;
  localparam logic [3:0] S_ISS     = 4'd7;
  localparam logic [3:0] S_ALU     = 4'd8;
  localparam logic [3:0] S_LSU_IN  = 4'd9;
  localparam logic [3:0] S_DAT_MEM = 4'd10;
  localparam logic [3:0] S_LSU_OUT = 4'd11;
  localparam logic [3:0] S_RFW     = 4'd12;
  localparam logic [3:0] S_PCA     = 4'd13;
  localparam logic [3:0] S_ERR     = 4'd15;
  logic [3:0]       r_state, w_next;
  logic [WW-1:0]    r_wait;
  logic             r_bootp, r_booted;
  logic [CNT_W-1:0] r_instret;
  logic             w_waiting, w_wait_end;
  assign w_waiting  = (r_state == S_INS_MEM) || (r_state == S_DAT_MEM);
  // r_wait holds the number of cycles already spent waiting before the current one
  assign w_wait_end = (r_wait == WW'(WAIT_MAX - 1));
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:    w_next = !start_i ? S_IDLE : boot_i ? S_PCA : r_booted ? S_IFE_IN : S_IDLE;
      S_BOO:     w_next = halt_i ? S_IDLE : S_IFE_IN;
      S_IFE_IN:  w_next = S_INS_MEM;
      S_INS_MEM: w_next = ins_rvalid_i ? S_IFE_OUT : w_wait_end ? S_ERR : S_INS_MEM;
      S_IFE_OUT: w_next = S_DEC;
      S_DEC:     w_next = S_RFR;
      S_RFR:     w_next = S_ISS;
      S_ISS:     w_next = S_ALU;
      S_ALU:     w_next = data_req_i ? S_LSU_IN : rf_we_i ? S_RFW : S_PCA;
      S_LSU_IN:  w_next = S_DAT_MEM;
      S_DAT_MEM: w_next = dat_rvalid_i ? (data_we_i ? S_PCA : S_LSU_OUT) : w_wait_end ? S_ERR : S_DAT_MEM;
      S_LSU_OUT: w_next = rf_we_i ? S_RFW : S_PCA;
      S_RFW:     w_next = S_PCA;
      S_PCA:     w_next = S_BOO;
      S_ERR:     w_next = S_ERR;
      default:   w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_bootp   <= 1'b0;
      r_booted  <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= (w_waiting && w_next == r_state) ? r_wait + 1'b1 : '0;
      if (r_state == S_IDLE && w_next == S_PCA)
        r_bootp <= 1'b1;
      else if (r_state == S_PCA)
        r_bootp <= 1'b0;
      if (r_state == S_PCA)
        r_booted <= 1'b1;
      if (r_state == S_PCA && !r_bootp)
        r_instret <= r_instret + 1'b1;
    end
  end
  assign en_boo_o     = r_state == S_BOO;
  assign en_ife_in_o  = r_state == S_IFE_IN;
  assign en_ins_mem_o = r_state == S_INS_MEM;
  assign en_ife_out_o = r_state == S_IFE_OUT;
  assign en_dec_o     = r_state == S_DEC;
  assign en_rfr_o     = r_state == S_RFR;
  assign en_iss_o     = r_state == S_ISS;
  assign en_alu_o     = r_state == S_ALU;
  assign en_lsu_in_o  = r_state == S_LSU_IN;
  assign en_dat_mem_o = r_state == S_DAT_MEM;
  assign en_lsu_out_o = r_state == S_LSU_OUT;
  assign en_rfw_o     = r_state == S_RFW;
  assign en_pca_o     = r_state == S_PCA;
  assign boot_o       = en_pca_o && r_bootp;
  assign busy_o       = (r_state != S_IDLE) && (r_state != S_ERR);
  assign err_o        = r_state == S_ERR;
  assign state_o      = r_state;
  assign instret_o    = r_instret;
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed scenario tasks for stage_sequencer with hand-computed state sequences.
module tb_stage_sequencer;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic start_i = 0, boot_i = 0, halt_i = 0, ins_rvalid_i = 1, dat_rvalid_i = 1;
  logic data_req_i = 0, data_we_i = 0, rf_we_i = 0;
  logic en_boo_o, en_ife_in_o, en_ins_mem_o, en_ife_out_o, en_dec_o, en_rfr_o, en_iss_o;
  logic en_alu_o, en_lsu_in_o, en_dat_mem_o, en_lsu_out_o, en_rfw_o, en_pca_o;
  logic boot_o, busy_o, err_o;
  logic [3:0] state_o;
  logic [31:0] instret_o;
  logic [15:0] en_vec;
  int tests = 0, fails = 0;
  always #5 clk_i = ~clk_i;
  stage_sequencer #(.WAIT_MAX(15), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .boot_i(boot_i), .halt_i(halt_i),
    .ins_rvalid_i(ins_rvalid_i), .dat_rvalid_i(dat_rvalid_i), .data_req_i(data_req_i),
    .data_we_i(data_we_i), .rf_we_i(rf_we_i), .en_boo_o(en_boo_o), .en_ife_in_o(en_ife_in_o),
    .en_ins_mem_o(en_ins_mem_o), .en_ife_out_o(en_ife_out_o), .en_dec_o(en_dec_o),
    .en_rfr_o(en_rfr_o), .en_iss_o(en_iss_o), .en_alu_o(en_alu_o), .en_lsu_in_o(en_lsu_in_o),
    .en_dat_mem_o(en_dat_mem_o), .en_lsu_out_o(en_lsu_out_o), .en_rfw_o(en_rfw_o),
    .en_pca_o(en_pca_o), .boot_o(boot_o), .busy_o(busy_o), .err_o(err_o),
    .state_o(state_o), .instret_o(instret_o));
  always_comb begin
    en_vec = '0;
    en_vec[1] = en_boo_o;     en_vec[2] = en_ife_in_o;  en_vec[3] = en_ins_mem_o;
    en_vec[4] = en_ife_out_o; en_vec[5] = en_dec_o;     en_vec[6] = en_rfr_o;
    en_vec[7] = en_iss_o;     en_vec[8] = en_alu_o;     en_vec[9] = en_lsu_in_o;
    en_vec[10] = en_dat_mem_o; en_vec[11] = en_lsu_out_o; en_vec[12] = en_rfw_o;
    en_vec[13] = en_pca_o;
  end
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask
  task automatic test_reset();
    rst_ni = 0;
    tick(); tick();
    rst_ni = 1;
    tests++;
    if (state_o !== 4'd0 || en_vec !== 16'd0 || boot_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b0 || instret_o !== 32'd0) begin
      fails++;
      $display("FAIL reset: state=%0d en=%h boot=%b err=%b busy=%b instret=%0d, required 0/0/0/0/0/0",
               state_o, en_vec, boot_o, err_o, busy_o, instret_o);
    end
  endtask
  task automatic test_boot();
    start_i = 1; boot_i = 1;
    tick();
    start_i = 0; boot_i = 0;
    tests++;
    if (state_o !== 4'd13 || boot_o !== 1'b1 || en_vec !== 16'h2000) begin
      fails++;
      $display("FAIL boot_pca: state=%0d boot=%b en=%h, required 13/1/2000", state_o, boot_o, en_vec);
    end
    tick();
    tests++;
    if (state_o !== 4'd1 || instret_o !== 32'd0 || boot_o !== 1'b0) begin
      fails++;
      $display("FAIL boot_boo: state=%0d instret=%0d boot=%b, required 1/0/0", state_o, instret_o, boot_o);
    end
  endtask
  task automatic test_alu();
    int seq[10] = '{2, 3, 4, 5, 6, 7, 8, 12, 13, 1};
    halt_i = 0; ins_rvalid_i = 1; data_req_i = 0; data_we_i = 0; rf_we_i = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (state_o !== 4'(seq[i]) || en_vec !== (16'd1 << seq[i])) begin
        fails++;
        $display("FAIL alu_seq[%0d]: state=%0d en=%h, required %0d/%h", i, state_o, en_vec, seq[i], 16'd1 << seq[i]);
      end
      if (seq[i] == 13) begin
        tests++;
        if (instret_o !== 32'd0 || boot_o !== 1'b0) begin
          fails++;
          $display("FAIL alu_pca: instret=%0d boot=%b, required 0/0", instret_o, boot_o);
        end
      end
    end
    tests++;
    if (instret_o !== 32'd1) begin
      fails++;
      $display("FAIL alu_instret: got %0d, required 1", instret_o);
    end
  endtask
  task automatic test_load();
    int seq[16] = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 10, 10, 10, 11, 12, 13, 1};
    int seen = 0;
    data_req_i = 1; data_we_i = 0; rf_we_i = 1; dat_rvalid_i = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      tests++;
      if (state_o !== 4'(seq[i]) || en_vec !== (16'd1 << seq[i])) begin
        fails++;
        $display("FAIL load_seq[%0d]: state=%0d en=%h, required %0d/%h", i, state_o, en_vec, seq[i], 16'd1 << seq[i]);
      end
      if (seq[i] == 10) seen++;
      dat_rvalid_i = (seen == 4) && (seq[i] == 10);
    end
    dat_rvalid_i = 1;
    tests++;
    if (instret_o !== 32'd2) begin
      fails++;
      $display("FAIL load_instret: got %0d, required 2", instret_o);
    end
  endtask
  task automatic test_store();
    int seq[11] = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 13, 1};
    data_req_i = 1; data_we_i = 1; rf_we_i = 0; dat_rvalid_i = 1;
    for (int i = 0; i < 11; i++) begin
      tick();
      tests++;
      if (state_o !== 4'(seq[i]) || en_lsu_out_o !== 1'b0 || en_rfw_o !== 1'b0) begin
        fails++;
        $display("FAIL store_seq[%0d]: state=%0d lsu_out=%b rfw=%b, required %0d/0/0", i, state_o, en_lsu_out_o, en_rfw_o, seq[i]);
      end
    end
    tests++;
    if (instret_o !== 32'd3) begin
      fails++;
      $display("FAIL store_instret: got %0d, required 3", instret_o);
    end
    data_req_i = 0; data_we_i = 0;
  endtask
  task automatic test_halt_restart();
    int seq[8] = '{3, 4, 5, 6, 7, 8, 9, 10};
    halt_i = 1;
    tick();
    halt_i = 0;
    tests++;
    if (state_o !== 4'd0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL halt: state=%0d busy=%b, required 0/0", state_o, busy_o);
    end
    start_i = 1; boot_i = 0;
    tick();
    start_i = 0;
    tests++;
    if (state_o !== 4'd2 || busy_o !== 1'b1) begin
      fails++;
      $display("FAIL restart: state=%0d busy=%b, required 2/1", state_o, busy_o);
    end
    data_req_i = 1; data_we_i = 0; rf_we_i = 1; dat_rvalid_i = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++;
      if (state_o !== 4'(seq[i])) begin
        fails++;
        $display("FAIL restart_seq[%0d]: state=%0d, required %0d", i, state_o, seq[i]);
      end
    end
    rst_ni = 0;
    tick();
    rst_ni = 1;
    tests++;
    if (state_o !== 4'd0 || instret_o !== 32'd0 || en_vec !== 16'd0) begin
      fails++;
      $display("FAIL reset_mid_dat: state=%0d instret=%0d en=%h, required 0/0/0", state_o, instret_o, en_vec);
    end
    start_i = 1; boot_i = 0;
    tick();
    start_i = 0;
    tests++;
    if (state_o !== 4'd0) begin
      fails++;
      $display("FAIL unbooted_start: state=%0d, required 0", state_o);
    end
    data_req_i = 0; dat_rvalid_i = 1;
  endtask
  task automatic test_timeout(input bit late_valid);
    start_i = 1; boot_i = 1;
    tick();
    start_i = 0; boot_i = 0; ins_rvalid_i = 0;
    tick(); tick(); tick();
    for (int i = 1; i <= 15; i++) begin
      tests++;
      if (state_o !== 4'd3) begin
        fails++;
        $display("FAIL ins_wait[%0d]: state=%0d, required 3", i, state_o);
      end
      if (i == 15) ins_rvalid_i = late_valid;
      tick();
    end
    ins_rvalid_i = 1;
    if (late_valid) begin
      tests++;
      if (state_o !== 4'd4 || err_o !== 1'b0) begin
        fails++;
        $display("FAIL late_valid: state=%0d err=%b, required 4/0", state_o, err_o);
      end
    end else begin
      tests++;
      if (state_o !== 4'd15 || err_o !== 1'b1 || en_vec !== 16'd0 || busy_o !== 1'b0) begin
        fails++;
        $display("FAIL timeout: state=%0d err=%b en=%h busy=%b, required 15/1/0/0", state_o, err_o, en_vec, busy_o);
      end
      start_i = 1; boot_i = 1;
      tick(); tick();
      start_i = 0; boot_i = 0;
      tests++;
      if (state_o !== 4'd15 || err_o !== 1'b1) begin
        fails++;
        $display("FAIL err_sticky: state=%0d err=%b, required 15/1", state_o, err_o);
      end
    end
    rst_ni = 0;
    tick();
    rst_ni = 1;
    tests++;
    if (state_o !== 4'd0 || err_o !== 1'b0) begin
      fails++;
      $display("FAIL err_reset: state=%0d err=%b, required 0/0", state_o, err_o);
    end
  endtask
  initial begin
    @(negedge clk_i);
    test_reset();
    test_boot();
    test_alu();
    test_load();
    test_store();
    test_halt_restart();
    test_timeout(1'b0);
    test_timeout(1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
